// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : time_set_pkg
// Purpose  : Shared types and constants for the HH:MM time-set controller:
//            FSM state encoding, per-position digit limits, display code
//            width, button bit positions and digit-limit helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [3:0] H10_MAX      = 4'd2;
  localparam logic [3:0] H1_MAX       = 4'd9;
  localparam logic [3:0] H1_MAX_AT_20 = 4'd3;
  localparam logic [3:0] M10_MAX      = 4'd5;
  localparam logic [3:0] M1_MAX       = 4'd9;

  localparam int DISP_W = 5;
  // Reserved for the display driver; this block never emits it.
  localparam logic [DISP_W-1:0] DISP_BLANK = 5'b10001;

  // Bit positions inside the packed button / rise vector.
  localparam int BTN_MODE = 3;
  localparam int BTN_NEXT = 2;
  localparam int BTN_UP   = 1;
  localparam int BTN_DOWN = 0;

  // Upper limit of digit 'pos' (0 = hours tens); the hours-ones limit
  // depends on the current hours-tens digit.
  function automatic logic [3:0] digit_max(input logic [1:0] pos, input logic [3:0] h10);
    logic [3:0] lim;
    case (pos)
      2'd0:    lim = H10_MAX;
      2'd1:    lim = (h10 == H10_MAX) ? H1_MAX_AT_20 : H1_MAX;
      2'd2:    lim = M10_MAX;
      default: lim = M1_MAX;
    endcase
    return lim;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : time_set_ctrl_if
// Purpose   : Bundles the buttons, live/edited time and display signals of
//             the time-set controller.
//   master : drives btn_mode/next/up/down, time_in; observes the rest
//   slave  : the controller (time_set_ctrl)
//   disps  : four 5-bit display codes, digit 0 in [19:15]
//   blink  : index of the blinking digit (0 = leftmost)
// Revision  : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;
  import time_set_pkg::*;

  logic                  btn_mode;
  logic                  btn_next;
  logic                  btn_up;
  logic                  btn_down;
  logic [15:0]           time_in;
  logic [15:0]           time_out;
  logic                  time_load;
  logic                  editing;
  logic [4*DISP_W-1:0]   disps;
  logic [1:0]            blink;

  modport master (
    output btn_mode, btn_next, btn_up, btn_down, time_in,
    input  time_out, time_load, editing, disps, blink
  );

  modport slave (
    input  btn_mode, btn_next, btn_up, btn_down, time_in,
    output time_out, time_load, editing, disps, blink
  );

endinterface
`default_nettype wire

// File: rtl/time_set_ctrl_btn_rise.sv
`default_nettype none
// ============================================================================
// Module   : btn_rise
// Purpose  : Rising-edge detector for WIDTH debounced levels.
//            The previous-level register resets to all ones so that a
//            button held through reset does not produce an edge.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   btn_i  : button levels
//   rise_o : one-cycle rise indication per bit
// Revision : 1.0 - initial release
// ============================================================================
module btn_rise #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= '1;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~btn_q;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Purpose  : HH:MM time-setting controller. RUN passes the live time to the
//            display; EDIT owns four BCD digit registers, blinks the selected
//            digit and applies up/down edits within per-position limits;
//            COMMIT emits a one-cycle load strobe with the edited time.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   bus    : time_set_ctrl_if.slave (buttons, time_in/out, load, display)
//   TIMEOUT: idle EDIT cycles before the edit is abandoned (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  time_set_ctrl_if.slave bus
);

  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e                 state_q;
  logic [1:0]             sel_q;
  logic [3:0][3:0]        dig_q;      // dig_q[0] = hours tens
  logic [CNT_W-1:0]       cnt_q;
  logic [15:0]            time_out_q;
  logic                   time_load_q;

  logic [3:0]             rise;
  logic [3:0][3:0]        dig_d;
  logic [3:0][3:0]        cap;
  logic [3:0]             cap_h10;
  logic [3:0]             lim;

  btn_rise #(
    .WIDTH (4)
  ) u_btn_rise (
    .clk    (clk),
    .reset  (reset),
    .btn_i  ({bus.btn_mode, bus.btn_next, bus.btn_up, bus.btn_down}),
    .rise_o (rise)
  );

  // Live time clamped into legal range on entry to EDIT; the hours-ones
  // limit uses the already-clamped hours-tens digit.
  assign cap_h10 = clamp_digit(bus.time_in[15:12], H10_MAX);
  assign cap = {clamp_digit(bus.time_in[3:0], M1_MAX),
                clamp_digit(bus.time_in[7:4], M10_MAX),
                clamp_digit(bus.time_in[11:8], digit_max(2'd1, cap_h10)),
                cap_h10};

  // Up/down result for the selected digit, including the 2x -> 23 clamp.
  always_comb begin
    dig_d = dig_q;
    lim   = digit_max(sel_q, dig_q[0]);
    if (rise[BTN_UP]) begin
      dig_d[sel_q] = (dig_q[sel_q] >= lim) ? 4'd0 : dig_q[sel_q] + 4'd1;
    end else if (rise[BTN_DOWN]) begin
      dig_d[sel_q] = (dig_q[sel_q] == 4'd0) ? lim : dig_q[sel_q] - 4'd1;
    end
    if ((dig_d[0] == H10_MAX) && (dig_d[1] > H1_MAX_AT_20)) begin
      dig_d[1] = H1_MAX_AT_20;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      sel_q       <= 2'd0;
      dig_q       <= '0;
      cnt_q       <= '0;
      time_out_q  <= 16'h0000;
      time_load_q <= 1'b0;
    end else begin
      time_load_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (rise[BTN_MODE]) begin
            dig_q   <= cap;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            state_q <= EDIT;
          end
        end
        EDIT: begin
          // Priority mode > next > up > down; lower rises are dropped.
          if (rise[BTN_MODE]) begin
            time_out_q  <= {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
            time_load_q <= 1'b1;
            state_q     <= COMMIT;
          end else if (rise[BTN_NEXT]) begin
            sel_q <= sel_q + 2'd1;
            cnt_q <= '0;
          end else if (rise[BTN_UP] || rise[BTN_DOWN]) begin
            dig_q <= dig_d;
            cnt_q <= '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.time_out  = time_out_q;
  assign bus.time_load = time_load_q;
  assign bus.editing   = (state_q != RUN);
  assign bus.blink     = (state_q == RUN) ? 2'd0 : sel_q;
  assign bus.disps     = (state_q == RUN) ?
      {1'b0, bus.time_in[15:12], 1'b0, bus.time_in[11:8],
       1'b0, bus.time_in[7:4],   1'b0, bus.time_in[3:0]} :
      {1'b0, dig_q[0], 1'b0, dig_q[1], 1'b0, dig_q[2], 1'b0, dig_q[3]};

endmodule
`default_nettype wire
